// File: rtl/demux1_4_router.sv
// demux1_4_router: routes one input word to one of four channels, or to all
// four in broadcast mode. Each channel has a 1-entry holding register.
// in_ready is combinational from the channel occupancy.
// Data reaches out_dataN only through the registers.
module demux1_4_router #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       xfer_count
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [7:0]       count_q;
    logic [7:0]       count_d;

    logic [3:0]       free;
    logic [3:0]       load;
    logic             accept;

    // A channel is free when it is empty or is being drained this cycle.
    always_comb begin
        free = ~valid_q | out_ready;
        if (in_bcast) begin
            in_ready = &free;
        end else begin
            in_ready = free[in_sel];
        end
        accept = in_valid && in_ready;
        load   = 4'b0000;
        if (accept) begin
            if (in_bcast) begin
                load = 4'b1111;
            end else begin
                load[in_sel] = 1'b1;
            end
        end
    end

    // A load wins over a same-cycle drain, so a channel can pass one word per cycle.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            data_d[n]  = data_q[n];
            valid_d[n] = valid_q[n];
            if (load[n]) begin
                data_d[n]  = in_data;
                valid_d[n] = 1'b1;
            end else if (valid_q[n] && out_ready[n]) begin
                valid_d[n] = 1'b0;
            end
        end
        count_d = accept ? count_q + 8'd1 : count_q;
    end

    // Channel registers and transfer counter. Reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
            end
            valid_q <= 4'b0000;
            count_q <= 8'd0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= data_d[n];
            end
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        out_data0  = data_q[0];
        out_data1  = data_q[1];
        out_data2  = data_q[2];
        out_data3  = data_q[3];
        out_valid  = valid_q;
        xfer_count = count_q;
    end

endmodule

// File: tb/tb_demux1_4_router.sv
// Directed testbench for demux1_4_router. Inputs are driven 1 ns after the
// rising edge. Outputs are sampled at the same point, or 1 ns after a drive
// when the combinational in_ready is being checked.
module tb_demux1_4_router;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] xfer_count;

    int n_checks = 0;
    int n_fail   = 0;

    demux1_4_router #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = 8'h00; in_sel = 2'b00; in_bcast = 1'b0;
        in_valid = 1'b0; out_ready = 4'b0000;
        step(); step();
        n_checks++;
        if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b exp 0000", out_valid); end
        n_checks++;
        if (xfer_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", xfer_count); end
        n_checks++;
        if ({out_data0, out_data1, out_data2, out_data3} !== 32'h0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h exp 0", out_data0, out_data1, out_data2, out_data3);
        end
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = s[1:0];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready sel=%0d got %b exp 1", s, in_ready); end
        end
        in_sel = 2'b00;
    endtask

    task automatic test_single();
        in_sel = 2'b10; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'b0000;
        step();
        in_valid = 1'b0; in_data = 8'hFF;
        n_checks++;
        if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL single_valid got %b exp 0100", out_valid); end
        n_checks++;
        if (out_data2 !== 8'hA5) begin n_fail++; $display("FAIL single_data2 got %h exp a5", out_data2); end
        n_checks++;
        if (xfer_count !== 8'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", xfer_count); end
        n_checks++;
        if ({out_data0, out_data1, out_data3} !== 24'h0) begin
            n_fail++; $display("FAIL single_others got %h %h %h exp 0", out_data0, out_data1, out_data3);
        end
    endtask

    task automatic test_stall();
        in_sel = 2'b01; in_data = 8'h11; in_valid = 1'b1;
        step();
        in_data = 8'h22;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_ch1 got %b exp 0", in_ready); end
        step();
        n_checks++;
        if (out_data1 !== 8'h11) begin n_fail++; $display("FAIL stall_data1 got %h exp 11", out_data1); end
        in_sel = 2'b11; in_data = 8'h33;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_ch3 got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 4'b1110) begin n_fail++; $display("FAIL stall_valid got %b exp 1110", out_valid); end
        n_checks++;
        if (out_data3 !== 8'h33 || out_data1 !== 8'h11) begin
            n_fail++; $display("FAIL stall_data got d1=%h d3=%h exp 11 33", out_data1, out_data3);
        end
        n_checks++;
        if (xfer_count !== 8'd3) begin n_fail++; $display("FAIL stall_count got %0d exp 3", xfer_count); end
    endtask

    task automatic test_back_to_back();
        in_sel = 2'b00; in_data = 8'h30; in_valid = 1'b1;
        step();
        out_ready = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h3C + 8'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d got %b exp 1", i, in_ready); end
            step();
            n_checks++;
            if (out_valid[0] !== 1'b1 || out_data0 !== 8'h3C + 8'(i)) begin
                n_fail++; $display("FAIL b2b_data i=%0d got v=%b d=%h exp v=1 d=%h", i, out_valid[0], out_data0, 8'h3C + 8'(i));
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (xfer_count !== 8'd8) begin n_fail++; $display("FAIL b2b_count got %0d exp 8", xfer_count); end
        step();
        n_checks++;
        if (out_valid !== 4'b1110) begin n_fail++; $display("FAIL b2b_drain got %b exp 1110", out_valid); end
        out_ready = 4'b0000;
    endtask

    task automatic test_bcast();
        in_bcast = 1'b1; in_data = 8'h5A; in_sel = 2'b00; in_valid = 1'b1;
        out_ready = 4'b1011;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bcast_blocked got %b exp 0", in_ready); end
        step();
        n_checks++;
        if (xfer_count !== 8'd8 || out_valid !== 4'b0100 || out_data2 !== 8'hA5) begin
            n_fail++; $display("FAIL bcast_no_accept got cnt=%0d v=%b d2=%h exp 8 0100 a5", xfer_count, out_valid, out_data2);
        end
        out_ready = 4'b1111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
        n_checks++;
        if (out_valid !== 4'b1111) begin n_fail++; $display("FAIL bcast_valid got %b exp 1111", out_valid); end
        n_checks++;
        if ({out_data0, out_data1, out_data2, out_data3} !== 32'h5A5A5A5A) begin
            n_fail++; $display("FAIL bcast_data got %h %h %h %h exp 5a", out_data0, out_data1, out_data2, out_data3);
        end
        n_checks++;
        if (xfer_count !== 8'd9) begin n_fail++; $display("FAIL bcast_count got %0d exp 9", xfer_count); end
        in_bcast = 1'b1; in_valid = 1'b0; in_data = 8'hEE;
        step();
        in_bcast = 1'b0;
        n_checks++;
        if (xfer_count !== 8'd9 || out_data1 !== 8'h5A) begin
            n_fail++; $display("FAIL idle_no_load got cnt=%0d d1=%h exp 9 5a", xfer_count, out_data1);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1; #1; rst = 1'b0;
        out_ready = 4'b1111; in_sel = 2'b01; in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in_data = 8'(i);
            step();
        end
        n_checks++;
        if (xfer_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d exp 255", xfer_count); end
        n_checks++;
        if (out_data1 !== 8'hFE) begin n_fail++; $display("FAIL wrap_data1 got %h exp fe", out_data1); end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (xfer_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got %0d exp 0", xfer_count); end
        step();
        out_ready = 4'b0000;
        n_checks++;
        if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL wrap_drained got %b exp 0000", out_valid); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_sel = s[1:0]; in_data = 8'h40 + 8'(s);
            step();
        end
        n_checks++;
        if (out_valid !== 4'b0111 || xfer_count !== 8'd3) begin
            n_fail++; $display("FAIL ar_preload got v=%b cnt=%0d exp 0111 3", out_valid, xfer_count);
        end
        in_sel = 2'b11; in_data = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || xfer_count !== 8'd0) begin
            n_fail++; $display("FAIL ar_immediate got v=%b cnt=%0d exp 0000 0", out_valid, xfer_count);
        end
        n_checks++;
        if ({out_data0, out_data1, out_data2} !== 24'h0) begin
            n_fail++; $display("FAIL ar_data got %h %h %h exp 0", out_data0, out_data1, out_data2);
        end
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 4'b0000 || out_data3 !== 8'h00 || xfer_count !== 8'd0) begin
            n_fail++; $display("FAIL ar_discard got v=%b d3=%h cnt=%0d exp 0000 00 0", out_valid, out_data3, xfer_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_bcast();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
